// File: rtl/gpio_rx_frame_parser_if.sv
// Byte-stream bundle around the frame parser.
//   fifo_rdata  : RX FIFO head byte (first-word-fall-through)
//   fifo_rempty : RX FIFO empty flag
//   fifo_rinc   : RX FIFO pop, one byte per cycle high
//   m_data      : payload byte out
//   m_valid     : m_data valid
//   m_ready     : downstream accepts when m_valid & m_ready
//   m_last      : final payload byte of a frame
// master = parser side, slave = FIFO/downstream side.
interface gpio_rx_frame_parser_if;
    logic [7:0] fifo_rdata;
    logic       fifo_rempty;
    logic       fifo_rinc;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        input  fifo_rdata, fifo_rempty, m_ready,
        output fifo_rinc, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_rdata, fifo_rempty, m_ready,
        input  fifo_rinc, m_data, m_valid, m_last
    );
endinterface

// File: rtl/gpio_rx_frame_parser.sv
// GPIO RX frame parser. Pops bytes from the RX FIFO, hunts for
// SOF / LEN / payload / checksum frames, buffers the payload and
// releases it on a valid/ready stream only when the checksum matches.
// Ports:
//   rclk, rrst_n : clock and synchronous active-low reset
//   bus          : FIFO read port and payload stream (master modport)
//   frame_done   : 1-cycle pulse, good frame accepted into the buffer
//   frame_err    : 1-cycle pulse, frame aborted
//   err_code     : cause of last abort (1 bad LEN, 2 checksum, 3 timeout)
//   frame_cnt    : good frames, saturating
//   err_cnt      : aborts, saturating
module gpio_rx_frame_parser #(
    parameter logic [7:0]  SOF_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    gpio_rx_frame_parser_if.master bus,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            err_cnt
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // Counter only needs to reach TIMEOUT-1; the abort fires on that idle cycle.
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MaxLen8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        StHunt,
        StLen,
        StPay,
        StCsum,
        StDrain
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    rd_q, rd_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic [15:0]   ecnt_q, ecnt_d;

    logic [7:0]    pay_mem [MAX_LEN];
    logic          mem_we;
    logic          pop;
    logic          drain;
    logic          last;
    logic          hs;

    assign drain = (state_q == StDrain);
    assign last  = drain && (rd_q == len_q - 8'd1);
    assign hs    = drain && bus.m_ready;

    // Pop is gated by reset so nothing is consumed while rrst_n is low.
    assign pop = rrst_n && !drain && !bus.fifo_rempty;

    assign bus.fifo_rinc = pop;
    assign bus.m_valid   = drain;
    assign bus.m_data    = drain ? pay_mem[rd_q[AW-1:0]] : 8'h00;
    assign bus.m_last    = last;

    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;
    assign frame_cnt  = fcnt_q;
    assign err_cnt    = ecnt_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StHunt: begin
                tmo_d = '0;
                if (pop && bus.fifo_rdata == SOF_BYTE) begin
                    state_d = StLen;
                end
            end
            StLen, StPay, StCsum: begin
                if (pop) begin
                    tmo_d = '0;
                    if (state_q == StLen) begin
                        if (bus.fifo_rdata == 8'd0 || bus.fifo_rdata > MaxLen8) begin
                            err_d   = 1'b1;
                            code_d  = 2'd1;
                            state_d = StHunt;
                        end else begin
                            len_d   = bus.fifo_rdata;
                            sum_d   = bus.fifo_rdata;
                            idx_d   = 8'd0;
                            state_d = StPay;
                        end
                    end else if (state_q == StPay) begin
                        mem_we = 1'b1;
                        idx_d  = idx_q + 8'd1;
                        sum_d  = sum_q + bus.fifo_rdata;
                        if (idx_q + 8'd1 == len_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        if (bus.fifo_rdata == sum_q) begin
                            done_d  = 1'b1;
                            rd_d    = 8'd0;
                            state_d = StDrain;
                        end else begin
                            err_d   = 1'b1;
                            code_d  = 2'd2;
                            state_d = StHunt;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    if (tmo_q == TmoLast) begin
                        tmo_d   = '0;
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                        state_d = StHunt;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            StDrain: begin
                tmo_d = '0;
                if (hs) begin
                    rd_d = rd_q + 8'd1;
                    if (last) begin
                        state_d = StHunt;
                    end
                end
            end
            default: state_d = StHunt;
        endcase

        fcnt_d = (done_d && fcnt_q != 16'hFFFF) ? fcnt_q + 16'd1 : fcnt_q;
        ecnt_d = (err_d && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q <= StHunt;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            rd_q    <= 8'd0;
            sum_q   <= 8'd0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            fcnt_q  <= 16'd0;
            ecnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            fcnt_q  <= fcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Payload storage needs no reset; it is only read after being written.
    always_ff @(posedge rclk) begin
        if (mem_we) begin
            pay_mem[idx_q[AW-1:0]] <= bus.fifo_rdata;
        end
    end

endmodule

// File: tb/tb_gpio_rx_frame_parser.sv
module tb_gpio_rx_frame_parser;
    localparam int unsigned MAXL = 16;
    localparam int unsigned TMO  = 32;

    typedef logic [7:0] byte_q_t[$];

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    always #5 rclk = ~rclk;

    gpio_rx_frame_parser_if bus();

    gpio_rx_frame_parser #(
        .SOF_BYTE (8'hA5),
        .MAX_LEN  (MAXL),
        .TIMEOUT  (TMO)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    // FIFO model: first-word-fall-through, written by the test tasks.
    logic [7:0] fifo_mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    assign bus.fifo_rdata  = fifo_mem[rd_ptr];
    assign bus.fifo_rempty = (rd_ptr == wr_ptr);

    always @(posedge rclk) begin
        if (bus.fifo_rinc) rd_ptr <= rd_ptr + 8'd1;
    end

    int cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];
    int done_pulses = 0;
    int err_pulses = 0;
    int stall_cnt = 0;

    // Stream monitor and scoreboard.
    initial begin
        logic       prev_stall = 1'b0;
        logic       prev_valid = 1'b0;
        logic       prev_done = 1'b0;
        logic       prev_err = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       prev_last = 1'b0;
        int         last_pop_cyc = -10;
        logic [8:0] exp;
        forever begin
            @(negedge rclk);
            if (!rrst_n) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
                prev_done  = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data ||
                        bus.m_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b data=%h last=%b want 1 %h %b",
                                 bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
                    end
                end
                if (bus.m_valid) begin
                    checks++;
                    if (bus.fifo_rinc !== 1'b0) begin
                        errors++;
                        $display("FAIL drain_pop: fifo_rinc=%b want 0", bus.fifo_rinc);
                    end
                end
                if (bus.m_valid && !prev_valid) begin
                    checks++;
                    if (cyc != last_pop_cyc + 1) begin
                        errors++;
                        $display("FAIL latency: first valid cycle %0d want %0d",
                                 cyc, last_pop_cyc + 1);
                    end
                end
                if (bus.m_valid && bus.m_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got %h last=%b want none",
                                 bus.m_data, bus.m_last);
                    end else begin
                        exp = sb.pop_front();
                        if ({bus.m_last, bus.m_data} !== exp) begin
                            errors++;
                            $display("FAIL stream_byte: got last=%b data=%h want last=%b data=%h",
                                     bus.m_last, bus.m_data, exp[8], exp[7:0]);
                        end
                    end
                end
                checks++;
                if (frame_done && frame_err) begin
                    errors++;
                    $display("FAIL pulse_excl: done=1 err=1 want not both");
                end
                checks++;
                if ((frame_done && prev_done) || (frame_err && prev_err)) begin
                    errors++;
                    $display("FAIL pulse_width: done=%b err=%b held two cycles want 1",
                             frame_done, frame_err);
                end
                if (frame_done) done_pulses++;
                if (frame_err) err_pulses++;
                if (bus.m_valid && !bus.m_ready) stall_cnt++;
                if (bus.fifo_rinc) last_pop_cyc = cyc;
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_valid = bus.m_valid;
                prev_done  = frame_done;
                prev_err   = frame_err;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Pushes a well-formed frame and its expected output bytes.
    task automatic push_frame(input byte_q_t pl);
        logic [7:0] s;
        s = 8'(pl.size());
        push_byte(8'hA5);
        push_byte(s);
        foreach (pl[i]) begin
            push_byte(pl[i]);
            s = s + pl[i];
            sb.push_back({(i == pl.size() - 1), pl[i]});
        end
        push_byte(s);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge rclk);
            #1;
            if (rd_ptr == wr_ptr && !bus.m_valid && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        cycles(2);
    endtask

    task automatic test_reset();
        push_byte(8'h00);
        bus.m_ready = 1'b1;
        cycles(3);
        checks++;
        if (bus.fifo_rinc !== 1'b0) begin
            errors++;
            $display("FAIL reset_rinc: got %b want 0", bus.fifo_rinc);
        end
        checks++;
        if ({bus.m_valid, bus.m_last, bus.m_data} !== 10'd0) begin
            errors++;
            $display("FAIL reset_stream: valid=%b last=%b data=%h want 0 0 00",
                     bus.m_valid, bus.m_last, bus.m_data);
        end
        checks++;
        if ({frame_done, frame_err, err_code} !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags: done=%b err=%b code=%0d want 0 0 0",
                     frame_done, frame_err, err_code);
        end
        checks++;
        if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: frame_cnt=%0d err_cnt=%0d want 0 0", frame_cnt, err_cnt);
        end
        rrst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_good_frame();
        int  d0 = done_pulses;
        int  e0 = err_pulses;
        int  n = 0;
        bit  seen = 1'b0;
        bit  ok;
        byte_q_t q;
        q = {8'h11, 8'h22, 8'h33};
        push_frame(q);
        for (int i = 0; i < 50; i++) begin
            @(negedge rclk);
            if (bus.m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        while (seen && bus.m_valid && n < 10) begin
            n++;
            @(negedge rclk);
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL good_burst: consecutive valid cycles %0d want 3", n);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL good_idle: timed out want idle"); end
        checks++;
        if (done_pulses - d0 != 1 || err_pulses - e0 != 0) begin
            errors++;
            $display("FAIL good_pulses: done=%0d err=%0d want 1 0",
                     done_pulses - d0, err_pulses - e0);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL good_cnt: frame_cnt=%0d want 1", frame_cnt);
        end
    endtask

    task automatic test_garbage();
        int d0 = done_pulses;
        int e0 = err_pulses;
        bit ok;
        byte_q_t q;
        q = {8'h7E};
        push_byte(8'h00);
        push_byte(8'hFF);
        push_frame(q);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL garbage_idle: timed out want idle"); end
        checks++;
        if (done_pulses - d0 != 1 || err_pulses - e0 != 0) begin
            errors++;
            $display("FAIL garbage_pulses: done=%0d err=%0d want 1 0",
                     done_pulses - d0, err_pulses - e0);
        end
        checks++;
        if (frame_cnt !== 16'd2 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL garbage_cnt: frame_cnt=%0d err_cnt=%0d want 2 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_checksum();
        int d0 = done_pulses;
        int e0 = err_pulses;
        bit ok;
        byte_q_t q;
        push_byte(8'hA5);
        push_byte(8'h02);
        push_byte(8'h10);
        push_byte(8'h20);
        push_byte(8'h31);  // correct sum would be 32
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL csum_idle: timed out want idle"); end
        checks++;
        if (err_pulses - e0 != 1 || done_pulses - d0 != 0) begin
            errors++;
            $display("FAIL csum_pulses: err=%0d done=%0d want 1 0",
                     err_pulses - e0, done_pulses - d0);
        end
        checks++;
        if (err_code !== 2'd2 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL csum_code: code=%0d err_cnt=%0d want 2 1", err_code, err_cnt);
        end
        d0 = done_pulses;
        q = {8'h5A, 8'hC3};
        push_frame(q);
        wait_idle(ok);
        checks++;
        if (done_pulses - d0 != 1 || frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL csum_recover: done=%0d frame_cnt=%0d want 1 3",
                     done_pulses - d0, frame_cnt);
        end
        checks++;
        if (err_code !== 2'd2) begin
            errors++;
            $display("FAIL csum_code_hold: code=%0d want 2", err_code);
        end
    endtask

    task automatic test_bad_len();
        int e0 = err_pulses;
        int d0;
        bit ok;
        byte_q_t q;
        push_byte(8'hA5);
        push_byte(8'h00);
        push_byte(8'hA5);
        push_byte(8'(MAXL + 1));
        wait_idle(ok);
        checks++;
        if (err_pulses - e0 != 2) begin
            errors++;
            $display("FAIL badlen_pulses: err=%0d want 2", err_pulses - e0);
        end
        checks++;
        if (err_code !== 2'd1 || err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL badlen_code: code=%0d err_cnt=%0d want 1 3", err_code, err_cnt);
        end
        // Exactly MAX_LEN is legal.
        d0 = done_pulses;
        q = {};
        for (int i = 0; i < int'(MAXL); i++) q.push_back(8'(8'hF0 + i * 3));
        push_frame(q);
        wait_idle(ok);
        checks++;
        if (!ok || done_pulses - d0 != 1 || frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL maxlen_frame: ok=%b done=%0d frame_cnt=%0d want 1 1 4",
                     ok, done_pulses - d0, frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_pulses;
        int s0 = stall_cnt;
        bit ok = 1'b0;
        byte_q_t q;
        q = {8'hAA, 8'hBB, 8'h3C};
        push_frame(q);
        for (int i = 0; i < 200; i++) begin
            @(posedge rclk);
            #1;
            bus.m_ready = (i % 3 == 0) ? 1'b1 : 1'(($urandom & 1) == 0 && i[0]);
            if (i > 4 && rd_ptr == wr_ptr && !bus.m_valid && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        bus.m_ready = 1'b1;
        cycles(2);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_idle: timed out want idle"); end
        checks++;
        if (stall_cnt - s0 == 0) begin
            errors++;
            $display("FAIL bp_stalls: stalls=0 want >0");
        end
        checks++;
        if (done_pulses - d0 != 1 || frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL bp_cnt: done=%0d frame_cnt=%0d want 1 5", done_pulses - d0, frame_cnt);
        end
    endtask

    task automatic test_timeout();
        int e0 = err_pulses;
        int n = 0;
        bit hit = 1'b0;
        push_byte(8'hA5);
        push_byte(8'h02);
        push_byte(8'hAA);
        for (int i = 0; i < 20 && rd_ptr != wr_ptr; i++) cycles(1);
        while (n < int'(TMO) + 8) begin
            cycles(1);
            if (err_pulses > e0) begin
                hit = 1'b1;
                break;
            end
            n++;
        end
        checks++;
        if (!hit || n < int'(TMO) - 4) begin
            errors++;
            $display("FAIL timeout_fire: hit=%b after %0d idle cycles want 1 near %0d",
                     hit, n, TMO);
        end
        checks++;
        if (err_code !== 2'd3 || err_cnt !== 16'd4) begin
            errors++;
            $display("FAIL timeout_code: code=%0d err_cnt=%0d want 3 4", err_code, err_cnt);
        end
        cycles(2);
    endtask

    task automatic test_reset_mid_pay();
        int d0;
        int e0;
        bit ok;
        byte_q_t q;
        push_byte(8'hA5);
        push_byte(8'h04);
        push_byte(8'h01);
        cycles(5);
        rrst_n = 1'b0;
        cycles(1);
        checks++;
        if (frame_cnt !== 16'd0 || err_cnt !== 16'd0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL rst_pay_cnt: frame_cnt=%0d err_cnt=%0d code=%0d want 0 0 0",
                     frame_cnt, err_cnt, err_code);
        end
        checks++;
        if ({bus.m_valid, frame_done, frame_err, bus.m_data} !== 11'd0) begin
            errors++;
            $display("FAIL rst_pay_out: valid=%b done=%b err=%b data=%h want 0 0 0 00",
                     bus.m_valid, frame_done, frame_err, bus.m_data);
        end
        rrst_n = 1'b1;
        cycles(1);
        d0 = done_pulses;
        e0 = err_pulses;
        q = {8'h01, 8'h02, 8'h03, 8'h04};
        push_frame(q);
        wait_idle(ok);
        checks++;
        if (!ok || done_pulses - d0 != 1 || err_pulses - e0 != 0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_pay_frame: ok=%b done=%0d err=%0d frame_cnt=%0d want 1 1 0 1",
                     ok, done_pulses - d0, err_pulses - e0, frame_cnt);
        end
    endtask

    initial begin
        bus.m_ready = 1'b1;
        test_reset();
        test_good_frame();
        test_garbage();
        test_checksum();
        test_bad_len();
        test_backpressure();
        test_timeout();
        test_reset_mid_pay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
